// File: rtl/maple_sched_if.sv
// maple_sched_if: request/transmit/receive handshake between the Maple port scheduler and its PHY-side peers.
interface maple_sched_if;
  logic       tick, tx_busy, rx_active, rx_done, tx_start, busy;
  logic [3:0] req, done, timeout;
  logic [1:0] port_sel;
  modport master (input tick, req, tx_busy, rx_active, rx_done, output port_sel, tx_start, busy, done, timeout);
  modport slave (output tick, req, tx_busy, rx_active, rx_done, input port_sel, tx_start, busy, done, timeout);
endinterface

// File: rtl/maple_port_scheduler.sv
// maple_port_scheduler: sequences Maple transactions over four ports sharing one PHY, round-robin grant.
// Define MAPLE_SCHED_FIXED_PRIO_EN to grant the lowest-index requester instead.
module maple_port_scheduler #(
  parameter logic [7:0] SETTLE_TICKS = 8'd4,
  parameter logic [7:0] RESP_TIMEOUT = 8'd200,
  parameter logic [7:0] RX_MAX_TICKS = 8'd255
) (
  input logic           clk,
  input logic           rst,
  maple_sched_if.master bus_io
);
  typedef enum logic [2:0] {IDLE, SETTLE, START, TX, WAIT_RX, RX, DONE, TOUT} state_e;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, grant;
  logic [3:0] done_q, tout_q;
  logic       tx_start_q, busy_q, tx_seen_q;
`ifdef MAPLE_SCHED_FIXED_PRIO_EN
  always_comb grant = bus_io.req[0] ? 2'd0 : bus_io.req[1] ? 2'd1 : bus_io.req[2] ? 2'd2 : 2'd3;
`else
  logic [1:0] last_q;
  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    grant = last_q;
    for (int i = 4; i >= 1; i--)
      if (bus_io.req[last_q + 2'(i)]) grant = last_q + 2'(i);
  end
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |bus_io.req ? SETTLE : IDLE;
      SETTLE:  state_d = cnt_q == SETTLE_TICKS ? START : SETTLE;
      START:   state_d = TX;
      TX:      state_d = tx_seen_q && !bus_io.tx_busy ? WAIT_RX : TX;
      WAIT_RX: state_d = bus_io.rx_done ? DONE : bus_io.rx_active ? RX : cnt_q == RESP_TIMEOUT ? TOUT : WAIT_RX;
      RX:      state_d = bus_io.rx_done ? DONE : (cnt_q == RX_MAX_TICKS || !bus_io.rx_active) ? TOUT : RX;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? 8'd0 : cnt_q + 8'(bus_io.tick && cnt_q != 8'hff);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      tx_seen_q  <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      tout_q     <= '0;
`ifndef MAPLE_SCHED_FIXED_PRIO_EN
      last_q     <= 2'd3;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_seen_q  <= state_q == TX;
      tx_start_q <= state_d == START;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE ? 4'b0001 << sel_q : 4'b0000;
      tout_q     <= state_d == TOUT ? 4'b0001 << sel_q : 4'b0000;
      if (state_q == IDLE && |bus_io.req) begin
        sel_q  <= grant;
`ifndef MAPLE_SCHED_FIXED_PRIO_EN
        last_q <= grant;
`endif
      end
    end
  end
  assign bus_io.port_sel = sel_q;
  assign bus_io.tx_start = tx_start_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.timeout  = tout_q;
endmodule

// File: tb/tb_maple_port_scheduler.sv
// tb_maple_port_scheduler: directed and randomized transactions against a tick-counting timing model.
module tb_maple_port_scheduler;
  localparam int SETTLE = 4, RESP = 200, RXMAX = 255;
  logic clk = 1'b0, rst = 1'b1;
  maple_sched_if bus ();
  maple_port_scheduler dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, per = 1;
  logic [1:0] last = 2'd3, sel = 2'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic tk(input int c);
    return (c % per) == 0;
  endfunction

  // cycle carrying the n-th tick counting from cycle 'from' inclusive
  function automatic int nth_tick(input int from, input int n);
    int k = 0;
    for (int c = from; c < from + 4 * n + 4; c++) begin
      if (tk(c)) k++;
      if (k == n) return c;
    end
    return -1;
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] r);
`ifdef MAPLE_SCHED_FIXED_PRIO_EN
    for (int p = 0; p < 4; p++) if (r[p]) return 2'(p);
`else
    for (int k = 1; k <= 4; k++) if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
`endif
    return last;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.tick = tk(cyc);
  endtask

  task automatic chk_out(input string tag, input logic b, input logic ts, input logic [3:0] d, input logic [3:0] t);
    chk({tag, ".sel"}, 8'(bus.port_sel), 8'(sel));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(b));
    chk({tag, ".tx_start"}, 8'(bus.tx_start), 8'(ts));
    chk({tag, ".done"}, 8'(bus.done), 8'(d));
    chk({tag, ".timeout"}, 8'(bus.timeout), 8'(t));
  endtask

  // kind: 0 no reply, 1 normal frame, 2 rx_active drops, 3 drop with rx_done, 4 short frame, 5 endless frame
  task automatic run_txn(input string tag, input logic [3:0] r, input int p, input int kind, input int txlen,
                         input int gap, input int rxlen, input bit drop, input bit noise);
    int G, S, W, A, E, act_end;
    bit ok;
    logic [3:0] oh;
    per = p;
    G = cyc;
    bus.req = r;
    sel = pick(r);
    last = sel;
    oh = 4'b0001 << sel;
    S = nth_tick(G + 1, SETTLE) + 2;
    W = (txlen + 1 > 2 ? S + txlen + 1 : S + 2) + 1;
    A = W + gap;
    ok = kind inside {1, 3, 4};
    case (kind)
      0: E = nth_tick(W, RESP) + 2;
      4: E = A + 1;
      5: E = nth_tick(A + 1, RXMAX) + 2;
      default: E = A + rxlen + 2;
    endcase
    act_end = kind == 1 ? A + rxlen + 2 : kind == 5 ? E : A + rxlen + 1;
    for (int c = G + 1; c <= E + 1; c++) begin
      step();
      bus.req = (drop && c > S) ? 4'b0000 : r;
      bus.tx_busy = c > S && c <= S + txlen;
      bus.rx_active = kind != 0 && kind != 4 && c >= A && c < act_end;
      bus.rx_done = (ok && c == E - 1) || (noise && c == G + 2);
      chk_out(tag, c <= E, c == S, (c == E && ok) ? oh : 4'b0000, (c == E && !ok) ? oh : 4'b0000);
    end
  endtask

  task automatic idle(input string tag, input int n);
    bus.req = 4'b0000;
    repeat (n) begin
      step();
      chk_out(tag, 1'b0, 1'b0, 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.req = '0; bus.tx_busy = 1'b0; bus.rx_active = 1'b0; bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 4'b0000, 4'b0000);
    rst = 1'b0;
    run_txn("first", 4'b0001, 1, 1, 10, 2, 4, 1'b0, 1'b0);
    idle("gap1", 2);
    for (int i = 0; i < 5; i++) begin
      run_txn("all_req", 4'b1111, 2, 1, 3, 1, 2, 1'b0, 1'b0);
`ifdef MAPLE_SCHED_FIXED_PRIO_EN
      chk("rr_order", 8'(bus.port_sel), 8'd0);
`else
      chk("rr_order", 8'(bus.port_sel), 8'((i + 1) % 4));
`endif
    end
    idle("gap2", 2);
    run_txn("no_reply", 4'b0100, 1, 0, 6, 0, 0, 1'b0, 1'b0);
    run_txn("rx_fall", 4'b1000, 2, 2, 2, 3, 5, 1'b0, 1'b0);
    run_txn("rx_fall_done", 4'b0010, 3, 3, 0, 1, 3, 1'b0, 1'b1);
    idle("gap3", 2);
    per = 1;
    bus.req = 4'b0100;
    sel = pick(4'b0100);
    last = sel;
    repeat (12) step();
    chk("pre_rst.busy", 8'(bus.busy), 8'd1);
    chk("pre_rst.sel", 8'(bus.port_sel), 8'd2);
    #2 rst = 1'b1;
    #1;
    last = 2'd3;
    sel = 2'd0;
    chk_out("mid_rst", 1'b0, 1'b0, 4'b0000, 4'b0000);
    #2 rst = 1'b0;
    run_txn("after_rst", 4'b0100, 1, 1, 4, 2, 3, 1'b0, 1'b0);
    run_txn("req_drop", 4'b0010, 1, 1, 5, 1, 2, 1'b1, 1'b0);
    idle("stay_idle", 6);
    run_txn("rx_watchdog", 4'b1000, 1, 5, 2, 0, 0, 1'b0, 1'b0);
    run_txn("short_frame", 4'b0001, 2, 4, 1, 4, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++)
      run_txn("random", 4'($urandom_range(1, 15)), int'($urandom_range(1, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle("final", 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
